// File: rtl/strip_pkg.sv
// Shared strip-addressing constants: geometry, strip start table and the decoder state encoding.
// The start table is shared with the forward strip ROM so both directions stay consistent.
package strip_pkg;

  localparam int NUM_STRIPS = 13;
  localparam int Y_W        = 7;
  localparam int ID_W       = 4;
  localparam int OFF_W      = 4;

  localparam logic [Y_W-1:0] STRIP_START [NUM_STRIPS] = '{
    7'd0,  7'd8,  7'd16, 7'd25, 7'd32, 7'd42, 7'd48,
    7'd59, 7'd64, 7'd76, 7'd80, 7'd96, 7'd112
  };

  // One past the last row; the upper bound of the final strip.
  localparam logic [Y_W:0] Y_END = 8'd128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/strip_y_decoder_if.sv
// Request/result bundle between pixel/row logic (master) and the y-to-strip decoder (slave).
interface strip_y_decoder_if;
  import strip_pkg::*;

  logic             req;
  logic [Y_W-1:0]   index_y;
  logic             busy;
  logic             done;
  logic [ID_W-1:0]  strip_id;
  logic [OFF_W-1:0] offset_y;
  logic             on_edge;

  modport master (
    output req, index_y,
    input  busy, done, strip_id, offset_y, on_edge
  );

  modport slave (
    input  req, index_y,
    output busy, done, strip_id, offset_y, on_edge
  );

endinterface

// File: rtl/strip_bound_table.sv
// Combinational strip bounds: start of strip k and start of strip k+1 (Y_END for the last strip).
module strip_bound_table
  import strip_pkg::*;
(
  input  logic [ID_W-1:0] k_i,
  output logic [Y_W:0]    start_o,
  output logic [Y_W:0]    next_o
);

  // Select both bounds; unmatched ids fall back to 0 / Y_END so the last strip needs no special case.
  always_comb begin
    start_o = {(Y_W+1){1'b0}};
    next_o  = Y_END;
    for (int i = 0; i < NUM_STRIPS; i++) begin
      if (k_i == ID_W'(i)) begin
        start_o = {1'b0, STRIP_START[i]};
      end else begin
        start_o = start_o;
      end
    end
    for (int i = 1; i < NUM_STRIPS; i++) begin
      if (k_i == ID_W'(i - 1)) begin
        next_o = {1'b0, STRIP_START[i]};
      end else begin
        next_o = next_o;
      end
    end
  end

endmodule

// File: rtl/strip_y_decoder.sv
// Inverse strip ROM: walks the strip start table one entry per cycle to find the strip holding y.
module strip_y_decoder
  import strip_pkg::*;
(
  input  logic               enclk,
  input  logic               rst_n,
  strip_y_decoder_if.slave   bus
);

  state_e           state_q, state_d;
  logic [ID_W-1:0]  k_q, k_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [OFF_W-1:0] off_q, off_d;
  logic             edge_q, edge_d;

  logic [Y_W:0]     start_s;
  logic [Y_W:0]     next_s;
  logic             hit_s;

  strip_bound_table u_bound_table (
    .k_i     (k_q),
    .start_o (start_s),
    .next_o  (next_s)
  );

  // The last-strip guard keeps the scan from stepping past the table.
  assign hit_s = (k_q == ID_W'(NUM_STRIPS - 1)) || ({1'b0, y_q} < next_s);

  // Next-state and registered-output computation.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    y_d     = y_q;
    done_d  = 1'b0;
    id_d    = id_q;
    off_d   = off_q;
    edge_d  = edge_q;
    case (state_q)
      IDLE: begin
        if (bus.req) begin
          y_d     = bus.index_y;
          k_d     = {ID_W{1'b0}};
          state_d = SCAN;
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        if (hit_s) begin
          id_d    = k_q;
          off_d   = OFF_W'(y_q - start_s[Y_W-1:0]);
          edge_d  = ({1'b0, y_q} == start_s);
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          k_d     = k_q + ID_W'(1);
          state_d = SCAN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge enclk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= {ID_W{1'b0}};
      y_q     <= {Y_W{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      id_q    <= {ID_W{1'b0}};
      off_q   <= {OFF_W{1'b0}};
      edge_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      id_q    <= id_d;
      off_q   <= off_d;
      edge_q  <= edge_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.strip_id = id_q;
  assign bus.offset_y = off_q;
  assign bus.on_edge  = edge_q;

endmodule

// File: tb/tb_strip_y_decoder.sv
// Self-checking bench for strip_y_decoder: timing-level reference model plus directed and random lookups.
module tb_strip_y_decoder;

  logic enclk = 1'b0;
  logic rst_n = 1'b0;
  strip_y_decoder_if bus ();

  strip_y_decoder dut (
    .enclk (enclk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 enclk = ~enclk;

  int tbl [13] = '{0, 8, 16, 25, 32, 42, 48, 59, 64, 76, 80, 96, 112};

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  // Largest k whose start is <= y.
  function automatic int strip_of(input int y);
    int k;
    k = 0;
    for (int i = 0; i < 13; i++) if (y >= tbl[i]) k = i;
    return k;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a lookup accepted at edge E reports at edge E+strip+1, done for one cycle.
  int   m_phase = 0;
  int   m_left  = 0;
  int   m_y     = 0;
  logic m_busy  = 1'b0;
  logic m_done  = 1'b0;
  int   m_id    = 0;
  int   m_off   = 0;
  logic m_edge  = 1'b0;

  always @(posedge enclk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      m_phase <= 0; m_left <= 0; m_y <= 0; m_busy <= 1'b0; m_done <= 1'b0;
      m_id <= 0; m_off <= 0; m_edge <= 1'b0;
    end else if (m_phase == 0) begin
      if (bus.req === 1'b1) begin
        m_y     <= int'(bus.index_y);
        m_left  <= strip_of(int'(bus.index_y)) + 1;
        m_phase <= 1;
        m_busy  <= 1'b1;
      end
    end else if (m_phase == 1) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_id    <= strip_of(m_y);
        m_off   <= m_y - tbl[strip_of(m_y)];
        m_edge  <= (m_y == tbl[strip_of(m_y)]);
        m_done  <= 1'b1;
        m_phase <= 2;
      end
    end else begin
      m_done  <= 1'b0;
      m_phase <= 0;
      m_busy  <= 1'b0;
    end
  end

  // Compare every DUT output against the model each cycle, away from the active edge.
  always @(negedge enclk) begin
    if (chk_en) begin
      chk("busy",     int'(bus.busy),     int'(m_busy));
      chk("done",     int'(bus.done),     int'(m_done));
      chk("strip_id", int'(bus.strip_id), m_id);
      chk("offset_y", int'(bus.offset_y), m_off);
      chk("on_edge",  int'(bus.on_edge),  int'(m_edge));
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge enclk);
    while (bus.busy !== 1'b0 && n < 40) begin
      @(negedge enclk);
      n++;
    end
    chk("idle_timeout", int'(n < 40), 1);
  endtask

  // Single lookup with literal expectations; latency counted in edges after the accept edge.
  task automatic lookup(input int y, input int e_id, input int e_off, input int e_edge, input int e_lat);
    int n;
    wait_idle();
    bus.req = 1'b1;
    bus.index_y = 7'(y);
    @(posedge enclk);
    #2 bus.req = 1'b0;
    n = 0;
    do begin
      @(posedge enclk);
      n++;
      @(negedge enclk);
    end while (bus.done !== 1'b1 && n < 20);
    chk("lat", n, e_lat);
    chk("lit_id", int'(bus.strip_id), e_id);
    chk("lit_off", int'(bus.offset_y), e_off);
    chk("lit_edge", int'(bus.on_edge), e_edge);
  endtask

  initial begin
    int last_done;
    int k;
    int n;
    int dones;
    bus.req = 1'b0;
    bus.index_y = 7'd0;
    rst_n = 1'b0;
    @(posedge enclk);
    #2 chk_en = 1'b1;
    @(negedge enclk);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_id",   int'(bus.strip_id), 0);
    rst_n = 1'b1;

    lookup(0,   0,  0, 1, 1);
    lookup(24,  2,  8, 0, 3);
    lookup(25,  3,  0, 1, 4);
    lookup(127, 12, 15, 0, 13);

    // Sweep with req held high; done pulses spaced strip+3 edges apart.
    wait_idle();
    bus.req = 1'b1;
    last_done = -1;
    for (int y = 0; y < 128; y++) begin
      bus.index_y = 7'(y);
      n = 0;
      do begin
        @(negedge enclk);
        n++;
      end while (bus.done !== 1'b1 && n < 30);
      k = strip_of(y);
      chk("sweep_id", int'(bus.strip_id), k);
      chk("sweep_off", int'(bus.offset_y), y - tbl[k]);
      if (last_done >= 0) chk("sweep_gap", cyc - last_done, k + 3);
      last_done = cyc;
    end
    bus.req = 1'b0;

    // Requests and y changes while busy are ignored.
    wait_idle();
    bus.req = 1'b1;
    bus.index_y = 7'd60;
    @(posedge enclk);
    #2 bus.req = 1'b0;
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge enclk);
      if (i < 5) begin
        bus.req = 1'($urandom_range(1, 0));
        bus.index_y = 7'($urandom_range(127, 0));
      end else begin
        bus.req = 1'b0;
      end
      if (bus.done === 1'b1) dones++;
    end
    chk("busy_dones", dones, 1);
    chk("busy_id", int'(bus.strip_id), 7);
    chk("busy_off", int'(bus.offset_y), 1);

    // Reset mid-scan aborts the lookup without a done.
    wait_idle();
    bus.req = 1'b1;
    bus.index_y = 7'd100;
    @(posedge enclk);
    #2 bus.req = 1'b0;
    repeat (5) @(posedge enclk);
    #2 rst_n = 1'b0;
    @(posedge enclk);
    #2 rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge enclk);
      if (bus.done === 1'b1) dones++;
    end
    chk("abort_dones", dones, 0);
    chk("abort_id", int'(bus.strip_id), 0);
    chk("abort_busy", int'(bus.busy), 0);
    lookup(80, 10, 0, 1, 11);

    // Random traffic, occasional resets; the per-cycle model comparison does the checking.
    for (int i = 0; i < 1500; i++) begin
      @(posedge enclk);
      #2;
      bus.req = 1'($urandom_range(3, 0) != 0);
      bus.index_y = 7'($urandom_range(127, 0));
      rst_n = ($urandom_range(199, 0) != 0);
    end
    rst_n = 1'b1;
    bus.req = 1'b0;
    repeat (20) @(posedge enclk);
    @(negedge enclk);
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
